// File: rtl/NetworkPkg.sv
// ---------------------------------------------------------------------------
// NetworkPkg
// Shared constants and types for the serial frame link. The sender, the
// receiver and the benches all pull the frame geometry and the sender state
// encoding from here so the two ends of the link cannot drift apart.
//
// Contents:
//   ENC_DATA_BITS  - width of the encoded payload carried by one frame
//   SYNC_BITS      - length of the synchronisation preamble
//   SYNC_WORD      - preamble pattern, sent MSB-first ahead of the payload
//   BIT_CNT_W      - width of a per-phase bit counter that can reach
//                    ENC_DATA_BITS without wrapping
//   sender_state_t - frame sender state encoding
// ---------------------------------------------------------------------------
package NetworkPkg;

    localparam int ENC_DATA_BITS = 216;
    localparam int SYNC_BITS     = 8;
    localparam logic [SYNC_BITS-1:0] SYNC_WORD = 8'hA7;

    localparam int BIT_CNT_W = $clog2(ENC_DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } sender_state_t;

endpackage

// File: rtl/serial_frame_sender.sv
// ---------------------------------------------------------------------------
// serial_frame_sender
// Serialises one frame per accepted request: SYNC_WORD MSB-first, then the
// captured payload MSB-first, one bit per clk. When no frame is in flight the
// line sits at IDLE_LEVEL.
//
// Parameters:
//   IDLE_LEVEL - serial_out level while no frame is in flight
//
// Ports:
//   clk        - single clock, rising edge
//   rst_l      - asynchronous active-low reset, aborts any frame in flight
//   send_start - frame request, sampled on the rising clk edge
//   data_in    - encoded payload, captured when a request is accepted
//   serial_out - registered serial line
//   send_ready - high while a request can be accepted
//   send_done  - one-cycle pulse on the edge that finishes a frame
// ---------------------------------------------------------------------------
module serial_frame_sender
    import NetworkPkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     send_start,
    input  logic [ENC_DATA_BITS-1:0] data_in,
    output logic                     serial_out,
    output logic                     send_ready,
    output logic                     send_done
);

    localparam int SYNC_IDX_W = $clog2(SYNC_BITS);

    sender_state_t            state;
    logic [BIT_CNT_W-1:0]     bit_cnt;
    logic [ENC_DATA_BITS-1:0] shift_reg;
    logic [SYNC_IDX_W-1:0]    sync_idx;

    // In SYNC the counter holds how many preamble bits are already on the
    // line, so the next preamble bit to send sits that many places below
    // the MSB of SYNC_WORD.
    always_comb begin
        sync_idx = SYNC_IDX_W'(SYNC_BITS - 1) - bit_cnt[SYNC_IDX_W-1:0];
    end

    // Frame sequencer. Every accepted request puts the first preamble bit on
    // the line at the accepting edge and starts the counter at one, so each
    // phase ends when the counter equals that phase's length. The edge that
    // finishes the payload also samples send_start: a pending request starts
    // the next frame right there, so continuous requests produce frames with
    // no idle bit between them. send_ready then stays low because the block
    // never passes through IDLE.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            serial_out <= IDLE_LEVEL;
            send_ready <= 1'b1;
            send_done  <= 1'b0;
        end else begin
            send_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_start) begin
                        state      <= SYNC;
                        shift_reg  <= data_in;
                        serial_out <= SYNC_WORD[SYNC_BITS-1];
                        bit_cnt    <= BIT_CNT_W'(1);
                        send_ready <= 1'b0;
                    end else begin
                        serial_out <= IDLE_LEVEL;
                        bit_cnt    <= '0;
                        send_ready <= 1'b1;
                    end
                end
                SYNC: begin
                    if (bit_cnt == BIT_CNT_W'(SYNC_BITS)) begin
                        state      <= DATA;
                        serial_out <= shift_reg[ENC_DATA_BITS-1];
                        shift_reg  <= {shift_reg[ENC_DATA_BITS-2:0], 1'b0};
                        bit_cnt    <= BIT_CNT_W'(1);
                    end else begin
                        serial_out <= SYNC_WORD[sync_idx];
                        bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_CNT_W'(ENC_DATA_BITS)) begin
                        send_done <= 1'b1;
                        if (send_start) begin
                            state      <= SYNC;
                            shift_reg  <= data_in;
                            serial_out <= SYNC_WORD[SYNC_BITS-1];
                            bit_cnt    <= BIT_CNT_W'(1);
                            send_ready <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            serial_out <= IDLE_LEVEL;
                            bit_cnt    <= '0;
                            send_ready <= 1'b1;
                        end
                    end else begin
                        serial_out <= shift_reg[ENC_DATA_BITS-1];
                        shift_reg  <= {shift_reg[ENC_DATA_BITS-2:0], 1'b0};
                        bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= IDLE_LEVEL;
                    bit_cnt    <= '0;
                    send_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
